mystic_div_ctrl: RTL and testbench

- Sequencing front-end between the execute stage and the multi-cycle integer divider core.
- Decodes RV64M divide ops: DIV, DIVU, REM, REMU and the W forms.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without the core.
- Holds a one-entry quotient/remainder cache so a DIV/REM pair on the same operands issues the core once; handles flush and result back-pressure.

---
 rtl/mystic_pkg.sv | 31 +++
 rtl/mystic_div_special.sv | 58 +++++
 rtl/mystic_div_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mystic_div_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mystic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mystic_pkg
// Description : Shared definitions for the divide controller and its
//               operand-preparation helper: op-field bit positions, FSM
//               state encodings, default datapath width and the RV64
//               most-negative constants used by overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
package mystic_pkg;

  localparam int XLEN_DEF   = 64;

  // req_op_i field positions
  localparam int OP_REM_BIT = 1;
  localparam int OP_UNS_BIT = 0;

  localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MOST_NEG_32 = 32'h8000_0000;

  // One-hot controller states
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_WAIT  = 5'b00100,
    S_RESP  = 5'b01000,
    S_DRAIN = 5'b10000
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mystic_div_special.sv
`default_nettype none
// ============================================================================
// Module      : mystic_div_special
// Description : Combinational operand preparation and RISC-V special-case
//               resolution for divide-class ops.
// Ports       : unsigned_i      - op is unsigned
//               word_i          - W-form (32-bit) op
//               rs1_i / rs2_i   - raw dividend / divisor
//               upper_o/lower_o - prepared dividend / divisor
//               upper_signed_o / lower_signed_o - operand signedness
//               is_special_o    - divide-by-zero or signed overflow
//               spec_quot_o / spec_rem_o - architectural special results
// Revision    : 1.0 - initial release
// ============================================================================
module mystic_div_special
  import mystic_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            unsigned_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] upper_o,
  output logic [XLEN-1:0] lower_o,
  output logic            upper_signed_o,
  output logic            lower_signed_o,
  output logic            is_special_o,
  output logic [XLEN-1:0] spec_quot_o,
  output logic [XLEN-1:0] spec_rem_o
);

  localparam logic [XLEN-1:0] c_MOST_NEG   = MOST_NEG_64[63 -: XLEN];
  localparam logic [XLEN-1:0] c_MOST_NEG_W = {{(XLEN-32){1'b1}}, MOST_NEG_32};

  logic            w_signed;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_most_neg;

  assign w_signed       = !unsigned_i;
  assign upper_signed_o = w_signed;
  assign lower_signed_o = w_signed;

  // W forms: sign-extend for signed ops, zero-extend for unsigned ops
  assign upper_o = word_i ? {{(XLEN-32){w_signed & rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
  assign lower_o = word_i ? {{(XLEN-32){w_signed & rs2_i[31]}}, rs2_i[31:0]} : rs2_i;

  assign w_most_neg = word_i ? c_MOST_NEG_W : c_MOST_NEG;
  assign w_div_zero = (lower_o == '0);
  assign w_overflow = w_signed && (upper_o == w_most_neg) && (lower_o == '1);

  assign is_special_o = w_div_zero || w_overflow;
  assign spec_quot_o  = w_div_zero ? '1 : upper_o;
  assign spec_rem_o   = w_div_zero ? upper_o : '0;

endmodule
`default_nettype wire

// File: rtl/mystic_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mystic_div_ctrl
// Description : Sequencing front-end between execute and the multi-cycle
//               divider core. Resolves special cases locally, keeps a
//               one-entry quotient/remainder cache, handles flush and
//               result back-pressure. One op outstanding at a time.
// Ports       : req_*   - request handshake, op, operands and tag
//               resp_*  - result handshake, data and tag
//               core_*  - start pulse, prepared operands, core results
//               flush_i - squash in-flight op; busy_o - not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mystic_div_ctrl
  import mystic_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int TAG_W    = 5,
  parameter int CACHE_EN = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_word_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o,
  output logic             core_start_o,
  output logic [XLEN-1:0]  core_upper_o,
  output logic [XLEN-1:0]  core_lower_o,
  output logic             core_upper_signed_o,
  output logic             core_lower_signed_o,
  input  logic [XLEN-1:0]  core_quot_i,
  input  logic [XLEN-1:0]  core_rem_i,
  input  logic             core_done_i
);

  state_e           r_state;
  logic             r_out_en;   // keeps req_ready_o low while in reset
  logic             r_op_rem;
  logic             r_word;
  logic [TAG_W-1:0] r_tag;

  logic             r_c_valid;
  logic [XLEN-1:0]  r_c_upper;
  logic [XLEN-1:0]  r_c_lower;
  logic             r_c_signed;
  logic             r_c_word;
  logic [XLEN-1:0]  r_c_quot;
  logic [XLEN-1:0]  r_c_rem;

  logic [XLEN-1:0]  w_upper;
  logic [XLEN-1:0]  w_lower;
  logic             w_upper_signed;
  logic             w_lower_signed;
  logic             w_special;
  logic [XLEN-1:0]  w_spec_quot;
  logic [XLEN-1:0]  w_spec_rem;
  logic             w_hit;
  logic             w_accept;

  function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] val);
    return word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
  endfunction

  mystic_div_special #(.XLEN(XLEN)) u_special (
    .unsigned_i     (req_op_i[OP_UNS_BIT]),
    .word_i         (req_word_i),
    .rs1_i          (req_rs1_i),
    .rs2_i          (req_rs2_i),
    .upper_o        (w_upper),
    .lower_o        (w_lower),
    .upper_signed_o (w_upper_signed),
    .lower_signed_o (w_lower_signed),
    .is_special_o   (w_special),
    .spec_quot_o    (w_spec_quot),
    .spec_rem_o     (w_spec_rem)
  );

  generate
    if (CACHE_EN != 0) begin : g_cache
      assign w_hit = r_c_valid && (r_c_upper == w_upper) && (r_c_lower == w_lower) &&
                     (r_c_signed == w_upper_signed) && (r_c_word == req_word_i);
    end else begin : g_no_cache
      assign w_hit = 1'b0;
    end
  endgenerate

  assign req_ready_o = r_out_en && (r_state == S_IDLE) && !flush_i;
  assign busy_o      = (r_state != S_IDLE);
  assign w_accept    = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state             <= S_IDLE;
      r_out_en            <= 1'b0;
      r_op_rem            <= 1'b0;
      r_word              <= 1'b0;
      r_tag               <= '0;
      r_c_valid           <= 1'b0;
      r_c_upper           <= '0;
      r_c_lower           <= '0;
      r_c_signed          <= 1'b0;
      r_c_word            <= 1'b0;
      r_c_quot            <= '0;
      r_c_rem             <= '0;
      resp_valid_o        <= 1'b0;
      resp_data_o         <= '0;
      resp_tag_o          <= '0;
      core_start_o        <= 1'b0;
      core_upper_o        <= '0;
      core_lower_o        <= '0;
      core_upper_signed_o <= 1'b0;
      core_lower_signed_o <= 1'b0;
    end else begin
      r_out_en     <= 1'b1;
      core_start_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_rem <= req_op_i[OP_REM_BIT];
            r_word   <= req_word_i;
            r_tag    <= req_tag_i;
            if (w_special) begin
              resp_data_o  <= fmt_result(req_word_i,
                                req_op_i[OP_REM_BIT] ? w_spec_rem : w_spec_quot);
              resp_tag_o   <= req_tag_i;
              resp_valid_o <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_hit) begin
              resp_data_o  <= fmt_result(req_word_i,
                                req_op_i[OP_REM_BIT] ? r_c_rem : r_c_quot);
              resp_tag_o   <= req_tag_i;
              resp_valid_o <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              core_upper_o        <= w_upper;
              core_lower_o        <= w_lower;
              core_upper_signed_o <= w_upper_signed;
              core_lower_signed_o <= w_lower_signed;
              core_start_o        <= 1'b1;
              r_state             <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (flush_i) begin
            // A completion coinciding with the flush is already consumed,
            // so draining would wait for a pulse that never comes.
            r_state <= core_done_i ? S_IDLE : S_DRAIN;
          end else if (core_done_i) begin
            resp_data_o  <= fmt_result(r_word, r_op_rem ? core_rem_i : core_quot_i);
            resp_tag_o   <= r_tag;
            resp_valid_o <= 1'b1;
            r_c_valid    <= 1'b1;
            r_c_upper    <= core_upper_o;
            r_c_lower    <= core_lower_o;
            r_c_signed   <= core_upper_signed_o;
            r_c_word     <= r_word;
            r_c_quot     <= core_quot_i;
            r_c_rem      <= core_rem_i;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_o <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (core_done_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          resp_valid_o <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mystic_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mystic_div_ctrl
// Description : Self-checking bench for mystic_div_ctrl with a behavioural
//               divider core (fixed latency) and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mystic_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic        req_word_i = 1'b0;
  logic [63:0] req_rs1_i = '0;
  logic [63:0] req_rs2_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [63:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        busy_o;
  logic        core_start_o;
  logic [63:0] core_upper_o;
  logic [63:0] core_lower_o;
  logic        core_upper_signed_o;
  logic        core_lower_signed_o;
  logic [63:0] core_quot_i = '0;
  logic [63:0] core_rem_i = '0;
  logic        core_done_i = 1'b0;

  mystic_div_ctrl #(.XLEN(64), .TAG_W(5), .CACHE_EN(1)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_op_i            (req_op_i),
    .req_word_i          (req_word_i),
    .req_rs1_i           (req_rs1_i),
    .req_rs2_i           (req_rs2_i),
    .req_tag_i           (req_tag_i),
    .flush_i             (flush_i),
    .resp_valid_o        (resp_valid_o),
    .resp_ready_i        (resp_ready_i),
    .resp_data_o         (resp_data_o),
    .resp_tag_o          (resp_tag_o),
    .busy_o              (busy_o),
    .core_start_o        (core_start_o),
    .core_upper_o        (core_upper_o),
    .core_lower_o        (core_lower_o),
    .core_upper_signed_o (core_upper_signed_o),
    .core_lower_signed_o (core_lower_signed_o),
    .core_quot_i         (core_quot_i),
    .core_rem_i          (core_rem_i),
    .core_done_i         (core_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural divider core: done pulses a few cycles after start
  int n_starts = 0;
  int core_cnt = 0;
  always @(posedge clk_i) begin
    core_done_i <= 1'b0;
    if (core_start_o) begin
      n_starts = n_starts + 1;
      core_cnt <= 3;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_done_i <= 1'b1;
        if (core_upper_signed_o) begin
          core_quot_i <= $signed(core_upper_o) / $signed(core_lower_o);
          core_rem_i  <= $signed(core_upper_o) % $signed(core_lower_o);
        end else begin
          core_quot_i <= core_upper_o / core_lower_o;
          core_rem_i  <= core_upper_o % core_lower_o;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int starts_at_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Called at a negedge; returns 1ns after the accepting edge
  task automatic send_req(input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    int guard = 0;
    while (!req_ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (!req_ready_o) bound_fail("send_req");
    req_op_i = op; req_word_i = word; req_rs1_i = a; req_rs2_i = b; req_tag_i = tag;
    req_valid_i = 1'b1;
    starts_at_req = n_starts;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!resp_valid_o && lat < 100);
    if (!resp_valid_o) bound_fail("wait_resp");
  endtask

  task automatic release_resp();
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] exp;
    int          starts;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    int guard;
    bit done_seen;
    logic [63:0] hold_data;
    logic [4:0]  hold_tag;

    // op encoding: bit1 = remainder, bit0 = unsigned
    vecs[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 1};                                   // DIVU
    vecs[1]  = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 0};                                    // REMU hit
    vecs[2]  = '{2'b00, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};                 // DIV /0
    vecs[3]  = '{2'b10, 1'b0, 64'h1234, 64'd0, 64'h1234, 0};                                // REM /0
    vecs[4]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0};     // DIV ovf
    vecs[5]  = '{2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0};                      // REMW ovf
    vecs[6]  = '{2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1};  // DIVW -7/2
    vecs[7]  = '{2'b01, 1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1};            // DIVUW
    vecs[8]  = '{2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1};  // REMW -7%2
    vecs[9]  = '{2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0};  // DIVW hit
    vecs[10] = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1};  // DIV -100/7
    vecs[11] = '{2'b11, 1'b1, 64'h1_0000_0005, 64'd3, 64'd2, 1};                            // REMUW
    vecs[12] = '{2'b01, 1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0};          // DIVUW /0

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_core_start", {63'd0, core_start_o}, 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {63'd0, req_ready_o}, 64'd1);

    for (int i = 0; i < 13; i++) begin
      send_req(vecs[i].op, vecs[i].word, vecs[i].rs1, vecs[i].rs2, 5'(i + 1));
      wait_resp(lat);
      chk($sformatf("v%0d_data", i), resp_data_o, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), {59'd0, resp_tag_o}, 64'(i + 1));
      chk($sformatf("v%0d_starts", i), 64'(n_starts - starts_at_req), 64'(vecs[i].starts));
      if (vecs[i].starts == 0) chk($sformatf("v%0d_latency", i), 64'(lat), 64'd1);
      if (i == 6) chk("divw_core_upper", core_upper_o, 64'hFFFF_FFFF_FFFF_FFF9);
      release_resp();
    end

    // Back-pressure: response held for 5 cycles
    send_req(2'b00, 1'b0, 64'h55, 64'd0, 5'd20);
    wait_resp(lat);
    hold_data = resp_data_o;
    hold_tag  = resp_tag_o;
    chk("bp_data", hold_data, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_hold_data", resp_data_o, hold_data);
      chk("bp_hold_tag", {59'd0, resp_tag_o}, {59'd0, hold_tag});
      chk("bp_valid", {63'd0, resp_valid_o}, 64'd1);
      chk("bp_ready_low", {63'd0, req_ready_o}, 64'd0);
    end
    release_resp();
    chk("bp_ready_after", {63'd0, req_ready_o}, 64'd1);

    // Flush in S_WAIT: DIVU 200/9 issued immediately after release
    send_req(2'b01, 1'b0, 64'd200, 64'd9, 5'd21);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    done_seen = 1'b0;
    guard = 0;
    while (!done_seen && guard < 50) begin
      @(negedge clk_i);
      guard++;
      chk("drain_no_resp", {63'd0, resp_valid_o}, 64'd0);
      chk("drain_ready_low", {63'd0, req_ready_o}, 64'd0);
      if (core_done_i) done_seen = 1'b1;
    end
    if (!done_seen) bound_fail("drain_done");
    @(negedge clk_i);
    chk("drain_ready_back", {63'd0, req_ready_o}, 64'd1);
    chk("drain_no_resp_end", {63'd0, resp_valid_o}, 64'd0);
    chk("drain_starts", 64'(n_starts - starts_at_req), 64'd1);

    // Cache still holds the REMUW 5,3 entry: DIVUW 5/3 hits
    send_req(2'b01, 1'b1, 64'd5, 64'd3, 5'd22);
    wait_resp(lat);
    chk("cache_kept_data", resp_data_o, 64'd1);
    chk("cache_kept_starts", 64'(n_starts - starts_at_req), 64'd0);
    chk("cache_kept_lat", 64'(lat), 64'd1);
    release_resp();

    // DIVU 100/7 no longer cached: core issued again
    send_req(2'b01, 1'b0, 64'd100, 64'd7, 5'd23);
    wait_resp(lat);
    chk("reissue_data", resp_data_o, 64'd14);
    chk("reissue_starts", 64'(n_starts - starts_at_req), 64'd1);
    release_resp();

    // Flush in S_RESP drops the response
    send_req(2'b10, 1'b0, 64'h77, 64'd0, 5'd24);
    wait_resp(lat);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("resp_flush_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("resp_flush_ready", {63'd0, req_ready_o}, 64'd1);

    // Flush in S_IDLE blocks a same-cycle request
    req_op_i = 2'b01; req_word_i = 1'b0; req_rs1_i = 64'd9; req_rs2_i = 64'd4; req_tag_i = 5'd25;
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("idle_flush_ready", {63'd0, req_ready_o}, 64'd0);
    @(posedge clk_i);
    #1 begin req_valid_i = 1'b0; flush_i = 1'b0; end
    @(negedge clk_i);
    chk("idle_flush_busy", {63'd0, busy_o}, 64'd0);
    chk("idle_flush_no_resp", {63'd0, resp_valid_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
